// File: rtl/bus_arbiter_rr_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr_pkg
//   Shared bus header for the bus arbiter slice.
//   - ENABLE_/DISABLE_ : polarity of the active-low bus strobes (req_, lock_,
//                        grnt_).
//   - OWNER_IDLE       : owner index reported while nobody owns the bus.
//   - prio_mode_e      : encoding of the prio_mode input.
// ---------------------------------------------------------------------------
package bus_arbiter_rr_pkg;

    localparam logic ENABLE_    = 1'b0;
    localparam logic DISABLE_   = 1'b1;

    localparam int   OWNER_IDLE = 0;

    typedef enum logic {
        PRIO_ROTATE = 1'b0,
        PRIO_FIXED  = 1'b1
    } prio_mode_e;

endpackage

// File: rtl/bus_rr_pick.sv
// ---------------------------------------------------------------------------
// bus_rr_pick
//   Combinational wrap-around first-one search. Scans req_i starting at
//   start_i, moving upward and wrapping modulo N, and reports the first set
//   bit.
//   Ports:
//     req_i   [N-1:0] : active-high request vector
//     start_i [W-1:0] : index where the search begins (must be < N)
//     idx_o   [W-1:0] : index of the first request found (0 if none)
//     found_o         : high when any request bit is set
// ---------------------------------------------------------------------------
module bus_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    logic [W-1:0] idx_s;
    logic         found_s;

    // start + offset, wrapped into 0..N-1 without a general modulo
    function automatic logic [W-1:0] wrap_idx(input logic [W-1:0] start, input int off);
        int sum;
        sum = int'(start) + off;
        if (sum >= N) begin
            sum = sum - N;
        end else begin
            sum = sum;
        end
        return W'(sum);
    endfunction

    // Priority scan from start_i; the first hit wins
    always_comb begin
        idx_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found_s && req_i[wrap_idx(start_i, i)]) begin
                found_s = 1'b1;
                idx_s   = wrap_idx(start_i, i);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign idx_o   = idx_s;
    assign found_o = found_s;

endmodule

// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
//   Bus arbiter with rotating or fixed priority, owner lock and hold-time
//   preemption. All strobes are active-low.
//   Ports:
//     clk        : clock, rising edge
//     reset      : synchronous, active-high
//     req_       : per-master request (active-low)
//     lock_      : per-master lock (active-low), only the owner's counts
//     prio_mode  : 0 rotating, 1 fixed (master 0 highest)
//     grnt_      : per-master grant (active-low), at most one low
//     owner      : index of current owner, 0 when idle
//     owner_vld  : high while some master owns the bus
//     preempt    : one-cycle pulse after an owner lost the bus by timeout
// ---------------------------------------------------------------------------
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_HOLD    = 16,
    parameter int OWNER_W     = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req_,
    input  logic [NUM_MASTERS-1:0] lock_,
    input  logic                   prio_mode,
    output logic [NUM_MASTERS-1:0] grnt_,
    output logic [OWNER_W-1:0]     owner,
    output logic                   owner_vld,
    output logic                   preempt
);

    // Counter only needs to reach MAX_HOLD-1
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    // With MAX_HOLD == 0 the counter parks at 0 and never triggers a timeout
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic                   owner_vld_q, owner_vld_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   preempt_q, preempt_d;

    logic [NUM_MASTERS-1:0] req_s;
    logic [NUM_MASTERS-1:0] owner_oh_s;
    logic [NUM_MASTERS-1:0] others_s;
    logic [NUM_MASTERS-1:0] pick_vec_s;
    logic                   owner_req_s;
    logic                   owner_locked_s;
    logic                   timeout_s;
    logic [OWNER_W-1:0]     start_s;
    logic [OWNER_W-1:0]     pick_idx_s;
    logic                   pick_found_s;

    assign req_s          = ~req_;
    assign owner_oh_s     = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner_q;
    assign others_s       = req_s & ~owner_oh_s;
    assign owner_req_s    = owner_vld_q && req_s[owner_q];
    assign owner_locked_s = owner_vld_q && (lock_[owner_q] == ENABLE_);
    assign timeout_s      = (MAX_HOLD != 0) && owner_req_s && !owner_locked_s &&
                            (hold_q == HOLD_SAT) && (|others_s);

    // The current owner never competes for the next slot: it either keeps the
    // bus outright or is being moved off it.
    assign pick_vec_s     = owner_vld_q ? others_s : req_s;

    // Search start: just past the owner in rotating mode, otherwise index 0
    always_comb begin
        if ((prio_mode == PRIO_ROTATE) && owner_vld_q) begin
            if (owner_q == OWNER_W'(NUM_MASTERS - 1)) begin
                start_s = '0;
            end else begin
                start_s = owner_q + OWNER_W'(1);
            end
        end else begin
            start_s = '0;
        end
    end

    bus_rr_pick #(
        .N (NUM_MASTERS),
        .W (OWNER_W)
    ) u_pick (
        .req_i   (pick_vec_s),
        .start_i (start_s),
        .idx_o   (pick_idx_s),
        .found_o (pick_found_s)
    );

    // Next-state: keep, hand over, or go idle
    always_comb begin
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        hold_d      = hold_q;
        preempt_d   = 1'b0;
        if (owner_req_s && !timeout_s) begin
            owner_vld_d = 1'b1;
            if (hold_q != HOLD_SAT) begin
                hold_d = hold_q + HOLD_W'(1);
            end else begin
                hold_d = hold_q;
            end
        end else begin
            // Idle, released, or timed out: fresh selection
            preempt_d = timeout_s;
            hold_d    = '0;
            if (pick_found_s) begin
                owner_d     = pick_idx_s;
                owner_vld_d = 1'b1;
            end else begin
                owner_d     = OWNER_W'(OWNER_IDLE);
                owner_vld_d = 1'b0;
            end
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= OWNER_W'(OWNER_IDLE);
            owner_vld_q <= 1'b0;
            hold_q      <= '0;
            preempt_q   <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            hold_q      <= hold_d;
            preempt_q   <= preempt_d;
        end
    end

    // Grant decode straight from the owner registers: one-cold or all-high
    always_comb begin
        grnt_ = {NUM_MASTERS{DISABLE_}};
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner_vld_q && (owner_q == OWNER_W'(i))) begin
                grnt_[i] = ENABLE_;
            end else begin
                grnt_[i] = DISABLE_;
            end
        end
    end

    assign owner     = owner_q;
    assign owner_vld = owner_vld_q;
    assign preempt   = preempt_q;

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of bus masters (legal 2..16).
REQ-002 SHALL have parameter MAX_HOLD, default 16, maximum cycles an owner keeps the bus while others wait; 0 = unlimited.
REQ-003 SHALL have parameter OWNER_W, default $clog2(NUM_MASTERS), width of the owner index.
REQ-004 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_  in  NUM_MASTERS  per-master bus request, active-low.
REQ-007 SHALL have port lock_  in  NUM_MASTERS  per-master lock, active-low; only honoured for the current owner.
REQ-008 SHALL have port prio_mode  in  1  0 = rotating priority, 1 = fixed priority (master 0 highest).
REQ-009 SHALL have port grnt_  out  NUM_MASTERS  per-master grant, active-low, one-cold or all-high.
REQ-010 SHALL have port owner  out  OWNER_W  index of current owner, 0 when idle.
REQ-011 SHALL have port owner_vld  out  1  high when some master owns the bus.
REQ-012 SHALL have port preempt  out  1  one-cycle pulse, high in the cycle after an owner was removed by hold timeout.

Function
REQ-013 SHALL hold state: owner register, owner_vld register, hold counter (saturating, width sufficient for MAX_HOLD).
REQ-014 SHALL decode grnt_ combinationally from the owner registers: grnt_[owner] low iff owner_vld, all other bits high.
REQ-015 SHALL grant with one-cycle latency: a request sampled at edge k from idle yields grnt_ low after edge k.
REQ-016 SHALL keep the current owner while its req_ is low, unless a timeout applies.
REQ-017 SHALL declare a timeout when MAX_HOLD != 0, hold counter == MAX_HOLD-1, owner lock_ high, owner req_ low, and at least one other req_ low.
REQ-018 SHALL on timeout move ownership to the next requester other than the current owner, and pulse preempt.
REQ-019 SHALL, when the owner releases (req_ high) or times out, select the next owner per prio_mode; if no request is pending, go idle.
REQ-020 SHALL in rotating mode search from index owner+1 upward with wrap-around modulo NUM_MASTERS; from idle, search from index 0.
REQ-021 SHALL in fixed mode search from index 0 upward regardless of previous owner.
REQ-022 SHALL reset the hold counter to 0 on every owner change or entry to idle, increment it each cycle ownership is retained, and saturate at MAX_HOLD-1.
REQ-023 SHALL ignore lock_ of non-owners and lock_ while idle.
REQ-024 SHALL let a locked owner hold the bus indefinitely while its req_ stays low; releasing req_ ends ownership even if lock_ is low.
REQ-025 SHALL allow prio_mode changes on any cycle; they affect the next selection only, never the current owner.
REQ-026 SHALL never assert more than one grnt_ low in any cycle.

Reset
REQ-027 SHALL, while reset is high at a rising edge, set owner=0, owner_vld=0, hold counter=0, preempt=0, giving all grnt_ high.
REQ-028 SHALL, on reset mid-ownership, drop the grant on the edge reset is sampled; arbitration resumes from idle on the first edge after reset falls.

Structure
REQ-029 SHALL place polarity constants (ENABLE_/DISABLE_) and the owner-idle encoding in the shared bus header.
REQ-030 SHALL implement the wrap-around search as a combinational sub-module bus_rr_pick (inputs: request vector, start index; outputs: index, found).

Verification (NUM_MASTERS=4, MAX_HOLD=4)
REQ-031 SHALL verify reset: reset high for 2 cycles with req_=4'b0000 -> grnt_=4'b1111, owner_vld=0; first edge after release -> grnt_=4'b1110.
REQ-032 SHALL verify rotation: owner 1 releases while req_ of masters 0,3 low, prio_mode=0 -> next owner 3, then after 3 releases -> owner 0.
REQ-033 SHALL verify fixed mode: same stimulus with prio_mode=1 -> next owner 0.
REQ-034 SHALL verify timeout: master 2 holds req_ low, master 0 requests, lock_ high -> grant to 2 lasts exactly 4 cycles, then owner 0 and preempt high one cycle.
REQ-035 SHALL verify lock: same as previous scenario with lock_[2] low -> master 2 keeps grant 20+ cycles, preempt never asserted.
REQ-036 SHALL verify the one-hot invariant by assertion on grnt_ over 10k cycles of random req_/lock_/prio_mode with reset pulses.
